// File: rtl/timer_ctrl_if.sv
// Kitchen-timer controller bundle: keypad/start/stop in, countdown-chain controls out.
// Latency: none, plain wires between controller, keypad front end and digit chain.
// Backpressure: none, every strobe is a single-cycle event with no ready signal.
interface timer_ctrl_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       chain_zero;
  logic [3:0] data_tens;
  logic [3:0] data_ones;
  logic       loadn;
  logic       clrn;
  logic       enable;
  logic       alarm;
  logic       busy;
  logic       key_err;

  // Controller side.
  modport master (
    input  key_valid, key_digit, start, stop, chain_zero,
    output data_tens, data_ones, loadn, clrn, enable, alarm, busy, key_err
  );

  // Keypad / digit-chain side.
  modport slave (
    output key_valid, key_digit, start, stop, chain_zero,
    input  data_tens, data_ones, loadn, clrn, enable, alarm, busy, key_err
  );
endinterface

// File: rtl/timer_ctrl.sv
// Kitchen-timer controller: keypad preset entry, load/run/pause/alarm sequencing of a BCD countdown chain.
// Latency: all outputs registered; first count enable TICK_DIV cycles after entering RUN.
// Backpressure: none; strobes act on the cycle they are seen. Macro TIMER_CTRL_RELOAD_EN keeps the preset across IDLE.
module timer_ctrl #(
  parameter int TICK_DIV    = 1000,
  parameter int ALARM_TICKS = 8
) (
  input logic          clock,
  input logic          clr,
  timer_ctrl_if.master ctl
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] AMAX = AW'(ALARM_TICKS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [AW-1:0] acnt, acnt_n;
  logic [3:0]    tens_q, tens_n;
  logic [3:0]    ones_q, ones_n;
  logic          loadn_q, clrn_q, clrn_n;
  logic          enable_q, enable_n;
  logic          alarm_q, busy_q;
  logic          key_err_q, key_err_n;
  logic          wrap;
  logic          to_idle;

  // Next-state, prescaler, preset and strobe decisions.
  always_comb begin
    state_n   = state;
    presc_n   = presc;
    acnt_n    = acnt;
    tens_n    = tens_q;
    ones_n    = ones_q;
    clrn_n    = 1'b1;
    enable_n  = 1'b0;
    key_err_n = 1'b0;
    to_idle   = 1'b0;
    wrap      = (presc == PMAX);

    case (state)
      IDLE: begin
        // A key in the same cycle as start takes precedence; start is dropped.
        if (ctl.key_valid) begin
          if ((ctl.key_digit > 4'd9) || (ones_q > 4'd5)) begin
            key_err_n = 1'b1;
          end else begin
            tens_n = ones_q;
            ones_n = ctl.key_digit;
          end
        end else if (ctl.start) begin
          if ((tens_q == 4'd0) && (ones_q == 4'd0)) begin
            key_err_n = 1'b1;
          end else begin
            state_n = LOAD;
          end
        end
      end

      LOAD: begin
        state_n = RUN;
        presc_n = '0;
      end

      RUN: begin
        // Stop freezes the prescaler and suppresses any tick due this cycle.
        if (ctl.stop) begin
          state_n = PAUSE;
        end else if (ctl.chain_zero && !enable_q) begin
          // Restart the prescaler so the alarm lasts exactly ALARM_TICKS full ticks.
          state_n = DONE;
          presc_n = '0;
          acnt_n  = '0;
        end else begin
          presc_n  = wrap ? '0 : presc + 1'b1;
          enable_n = wrap;
        end
      end

      PAUSE: begin
        if (ctl.stop) begin
          to_idle = 1'b1;
        end else if (ctl.start) begin
          state_n = RUN;
        end
      end

      DONE: begin
        presc_n = wrap ? '0 : presc + 1'b1;
        if (ctl.stop) begin
          to_idle = 1'b1;
        end else if (wrap) begin
          if (acnt == AMAX) begin
            to_idle = 1'b1;
          end else begin
            acnt_n = acnt + 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    // Returning to IDLE after an abort or alarm clears the chain for one cycle.
    if (to_idle) begin
      state_n = IDLE;
      clrn_n  = 1'b0;
      presc_n = '0;
      acnt_n  = '0;
`ifdef TIMER_CTRL_RELOAD_EN
      tens_n  = tens_q;
      ones_n  = ones_q;
`else
      tens_n  = 4'd0;
      ones_n  = 4'd0;
`endif
    end
  end

  // State and registered outputs; level outputs decoded from the next state.
  always_ff @(posedge clock) begin
    if (clr) begin
      state     <= IDLE;
      presc     <= '0;
      acnt      <= '0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      loadn_q   <= 1'b1;
      clrn_q    <= 1'b0;
      enable_q  <= 1'b0;
      alarm_q   <= 1'b0;
      busy_q    <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      acnt      <= acnt_n;
      tens_q    <= tens_n;
      ones_q    <= ones_n;
      loadn_q   <= (state_n != LOAD);
      clrn_q    <= clrn_n;
      enable_q  <= enable_n;
      alarm_q   <= (state_n == DONE);
      busy_q    <= (state_n == LOAD) || (state_n == RUN) || (state_n == PAUSE);
      key_err_q <= key_err_n;
    end
  end

  assign ctl.data_tens = tens_q;
  assign ctl.data_ones = ones_q;
  assign ctl.loadn     = loadn_q;
  assign ctl.clrn      = clrn_q;
  assign ctl.enable    = enable_q;
  assign ctl.alarm     = alarm_q;
  assign ctl.busy      = busy_q;
  assign ctl.key_err   = key_err_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl with a behavioural mod-6/mod-10 countdown chain attached.
// Latency: checks are cycle-exact against hand-derived schedules (TICK_DIV=4, ALARM_TICKS=2).
// Backpressure: not applicable; strobes are driven one cycle wide.
module tb_timer_ctrl;

`ifdef TIMER_CTRL_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  localparam logic [13:0] RST_VEC = 14'h0020;

  logic clock = 1'b0;
  logic clr   = 1'b1;

  timer_ctrl_if tc ();

  timer_ctrl #(.TICK_DIV(4), .ALARM_TICKS(2)) dut (
    .clock (clock),
    .clr   (clr),
    .ctl   (tc.master)
  );

  always #5 clock = ~clock;

  // Countdown chain model: registered digits, zero flag decoded from them.
  logic [3:0] ch_tens = 4'd0;
  logic [3:0] ch_ones = 4'd0;
  always_ff @(posedge clock) begin
    if (!tc.clrn) begin
      ch_tens <= 4'd0;
      ch_ones <= 4'd0;
    end else if (!tc.loadn) begin
      ch_tens <= tc.data_tens;
      ch_ones <= tc.data_ones;
    end else if (tc.enable) begin
      if (ch_ones == 4'd0) begin
        ch_ones <= 4'd9;
        ch_tens <= (ch_tens == 4'd0) ? 4'd5 : ch_tens - 4'd1;
      end else begin
        ch_ones <= ch_ones - 4'd1;
      end
    end
  end
  assign tc.chain_zero = (ch_tens == 4'd0) && (ch_ones == 4'd0);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {tc.data_tens, tc.data_ones, tc.loadn, tc.clrn, tc.enable, tc.alarm, tc.busy, tc.key_err};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    tc.key_valid = 1'b1;
    tc.key_digit = d;
    tick();
    tc.key_valid = 1'b0;
    tc.key_digit = 4'd0;
  endtask

  task automatic pulse_start();
    tc.start = 1'b1;
    tick();
    tc.start = 1'b0;
  endtask

  task automatic pulse_stop();
    tc.stop = 1'b1;
    tick();
    tc.stop = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_en, first_en, last_en, en_bad, n_alarm, first_alarm, n_loadn, j;
    tc.key_valid = 1'b0;
    tc.key_digit = 4'd0;
    tc.start     = 1'b0;
    tc.stop      = 1'b0;

    // Reset values while clr is held, then clrn released.
    tick();
    check("rst_outs_a", outs(), RST_VEC);
    tick();
    check("rst_outs_b", outs(), RST_VEC);
    clr = 1'b0;
    tick();
    check("rst_release", outs(), 14'h0030);

    // Preset 12, full countdown, alarm, timed return to IDLE.
    press(4'd1);
    check("key1_preset", {tc.data_tens, tc.data_ones}, 8'h01);
    press(4'd2);
    check("key2_preset", {tc.data_tens, tc.data_ones}, 8'h12);
    pulse_start();
    check("load_loadn", tc.loadn, 1'b0);
    check("load_busy", tc.busy, 1'b1);
    tick();
    n_en = 0; first_en = -1; last_en = -1; en_bad = 0;
    n_alarm = 0; first_alarm = -1; n_loadn = 0;
    for (int k = 0; k < 60; k++) begin
      if (tc.enable) begin
        n_en++;
        if (first_en < 0) first_en = k;
        last_en = k;
      end
      if (tc.enable !== (k > 0 && k <= 48 && (k % 4) == 0)) en_bad++;
      if (tc.alarm) begin
        n_alarm++;
        if (first_alarm < 0) first_alarm = k;
      end
      if (!tc.loadn) n_loadn++;
      if (k == 49) check("busy_before_done", tc.busy, 1'b1);
      if (k == 50) check("done_busy", tc.busy, 1'b0);
      if (k == 58) begin
        check("done_exit_clrn", tc.clrn, 1'b0);
        check("done_exit_alarm", tc.alarm, 1'b0);
        check("done_exit_preset", {tc.data_tens, tc.data_ones}, RELOAD ? 8'h12 : 8'h00);
      end
      if (k == 59) check("idle_clrn", tc.clrn, 1'b1);
      if (k < 59) tick();
    end
    check("run_enable_count", n_en, 12);
    check("run_first_enable", first_en, 4);
    check("run_last_enable", last_en, 48);
    check("run_enable_pattern", en_bad, 0);
    check("alarm_first", first_alarm, 50);
    check("alarm_cycles", n_alarm, 8);
    check("loadn_outside_load", n_loadn, 0);

    // Key rejection: tens overflow and non-BCD digit.
    do_reset();
    press(4'd7);
    check("key7_preset", {tc.data_tens, tc.data_ones}, 8'h07);
    check("key7_err", tc.key_err, 1'b0);
    press(4'd3);
    check("key3_err", tc.key_err, 1'b1);
    check("key3_preset", {tc.data_tens, tc.data_ones}, 8'h07);
    tick();
    check("key_err_one_cycle", tc.key_err, 1'b0);
    press(4'hA);
    check("keyA_err", tc.key_err, 1'b1);
    check("keyA_preset", {tc.data_tens, tc.data_ones}, 8'h07);

    // Start with preset 00, then start together with a key.
    do_reset();
    pulse_start();
    check("start00_err", tc.key_err, 1'b1);
    check("start00_loadn", tc.loadn, 1'b1);
    check("start00_busy", tc.busy, 1'b0);
    tc.start = 1'b1;
    press(4'd5);
    tc.start = 1'b0;
    check("start_key_preset", {tc.data_tens, tc.data_ones}, 8'h05);
    tick();
    check("start_key_busy", tc.busy, 1'b0);
    check("start_key_loadn", tc.loadn, 1'b1);

    // Pause / resume / abort from preset 05.
    pulse_start();
    tick();
    n_en = 0;
    for (int k = 0; k < 10; k++) begin
      if (tc.enable) n_en++;
      if (k < 9) tick();
    end
    check("pause_pre_enables", n_en, 2);
    tc.stop      = 1'b1;
    tc.key_valid = 1'b1;
    tc.key_digit = 4'd3;
    tick();
    tc.stop      = 1'b0;
    tc.key_valid = 1'b0;
    check("pause_busy", tc.busy, 1'b1);
    check("pause_key_ignored", {tc.data_tens, tc.data_ones, tc.key_err}, 9'h0A);
    n_en = 0;
    for (int k = 0; k < 5; k++) begin
      if (tc.enable) n_en++;
      tick();
    end
    check("pause_no_enable", n_en, 0);
    pulse_start();
    j = 0;
    while (j < 10 && !tc.enable) begin
      tick();
      j++;
    end
    check("resume_enable_delay", j, 3);
    pulse_stop();
    check("pause2_busy", tc.busy, 1'b1);
    check("pause2_enable", tc.enable, 1'b0);
    pulse_stop();
    check("abort_clrn", tc.clrn, 1'b0);
    check("abort_busy", tc.busy, 1'b0);
    check("abort_preset", {tc.data_tens, tc.data_ones}, RELOAD ? 8'h05 : 8'h00);
    tick();
    check("abort_clrn_release", tc.clrn, 1'b1);

    // clr in the middle of RUN.
    do_reset();
    press(4'd1);
    press(4'd5);
    pulse_start();
    for (int k = 0; k < 6; k++) tick();
    clr = 1'b1;
    tick();
    check("midrun_clr_outs", outs(), RST_VEC);
    clr = 1'b0;
    tick();
    check("midrun_release", outs(), 14'h0030);
    press(4'd3);
    check("midrun_idle_key", {tc.data_tens, tc.data_ones}, 8'h03);

    // Stop on the first alarm cycle, then optional reload.
    press(4'd0);
    press(4'd1);
    check("preset01", {tc.data_tens, tc.data_ones}, 8'h01);
    pulse_start();
    tick();
    j = 0;
    while (j < 20 && !tc.alarm) begin
      tick();
      j++;
    end
    check("alarm_delay_01", j, 6);
    pulse_stop();
    check("silence_alarm", tc.alarm, 1'b0);
    check("silence_clrn", tc.clrn, 1'b0);
    check("silence_busy", tc.busy, 1'b0);
    pulse_start();
    check("reload_loadn", tc.loadn, RELOAD ? 1'b0 : 1'b1);
    check("reload_key_err", tc.key_err, RELOAD ? 1'b0 : 1'b1);
    check("reload_preset", {tc.data_tens, tc.data_ones}, RELOAD ? 8'h01 : 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
